product_accumulator: RTL
========================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter B, default 8: width of the signed product consumed from the multiplier stage.
REQ-002 SHALL have parameter ACC_W, default 10: accumulator width, signed.
REQ-003 SHALL have parameter N_TERMS, default 8: number of products per accumulation run, range 2..255.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: begin a new accumulation run.
REQ-007 SHALL have port prod_valid, input, 1: prod carries a valid product.
REQ-008 SHALL have port prod, input, B, signed: product from the multiplier.
REQ-009 SHALL have port prod_ready, output, 1: the block accepts prod this cycle.
REQ-010 SHALL have port acc_out, output, ACC_W, signed: accumulated result, registered.
REQ-011 SHALL have port acc_valid, output, 1: acc_out holds a completed run.
REQ-012 SHALL have port res_ready, input, 1: the consumer takes the result.
REQ-013 SHALL have port busy, output, 1: high in ACCUM.
REQ-014 SHALL have port ovf, output, 1: sticky signed overflow flag for the current run.

Function
REQ-015 SHALL implement states IDLE, ACCUM and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL clear acc_out, ovf and the term counter, and enter ACCUM on the next edge.
REQ-017 In ACCUM, start=1 SHALL restart the run with the same clearing; a prod presented that cycle SHALL be dropped.
REQ-018 prod_ready SHALL equal (state==ACCUM) && !start, combinationally.
REQ-019 A product is accepted only when prod_valid && prod_ready; each accept SHALL add sign-extended prod to acc_out and increment the counter.
REQ-020 On the N_TERMS-th accept, the next state SHALL be DONE, and acc_valid SHALL rise on the edge after that accept.
REQ-021 In DONE, acc_valid=1 and acc_out SHALL hold stable until res_ready=1; the cycle after res_ready=1 the block SHALL enter IDLE with acc_valid=0.
REQ-022 prod_valid outside ACCUM SHALL be ignored, with no state change.
REQ-023 Gaps in prod_valid SHALL stall the run without losing count; there is no timeout.
REQ-024 ovf SHALL set when the true sum of acc_out and the extended prod falls outside the ACC_W signed range, and SHALL remain set until the next start or rst.

Reset
REQ-025 rst=1 SHALL force IDLE and set acc_out=0, acc_valid=0, ovf=0, busy=0, counter=0 and prod_ready=0, overriding start mid-operation.

Configuration
REQ-026 With PRODUCT_ACC_SAT_EN defined, an overflowing add SHALL clamp acc_out to 2^(ACC_W-1)-1 or -2^(ACC_W-1); later adds continue from the clamped value.
REQ-027 Without PRODUCT_ACC_SAT_EN, acc_out SHALL wrap modulo 2^ACC_W, and ovf SHALL still be set per REQ-024.

Structure
REQ-028 Package product_acc_pkg SHALL hold the state enum type and the default values of B, ACC_W and N_TERMS.
REQ-029 The add/clamp/overflow datapath SHALL be a sub-module named acc_sat_add; the FSM and counter remain in product_accumulator.

Verification
REQ-030 Reset check: after rst, acc_out=0, acc_valid=0, busy=0, prod_ready=0 and ovf=0.
REQ-031 Basic run: start, then 8 accepts of prod=10 -> acc_out=80, ovf=0, with acc_valid high one cycle after the 8th accept.
REQ-032 Positive overflow: 8 accepts of prod=105 -> SAT build acc_out=511, ovf=1; wrap build acc_out=-184, ovf=1.
REQ-033 Negative overflow: 8 accepts of prod=-120 -> SAT build acc_out=-512, ovf=1; wrap build acc_out=64, ovf=1.
REQ-034 Backpressure and bubbles:
- prod_valid toggling every other cycle still yields a correct sum.
- res_ready held low for 5 cycles in DONE keeps acc_out stable and acc_valid=1.
- prod_valid in DONE is not accepted.
REQ-035 Restart:
- start after 3 accepts clears acc_out and the count; the next 8 accepts of prod=1 give acc_out=8.
- rst asserted mid-ACCUM returns the block to IDLE with zeroed outputs.

Source files
------------

// File: rtl/product_acc_pkg.sv
// Shared types and default sizing for the product accumulator.
package product_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int B_DEF       = 8;
    localparam int ACC_W_DEF   = 10;
    localparam int N_TERMS_DEF = 8;

    // Term counter width; N_TERMS is capped at 255.
    localparam int CNT_W = 8;

endpackage

// File: rtl/acc_sat_add.sv
// Signed accumulate step: acc + sign-extended prod, with overflow detect.
// Define PRODUCT_ACC_SAT_EN to clamp on overflow; otherwise the sum wraps.
module acc_sat_add
    import product_acc_pkg::*;
#(
    parameter int B     = B_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [B-1:0]     prod,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    // One guard bit above the wider operand holds the true sum exactly.
    localparam int EXT_W = ((B > ACC_W) ? B : ACC_W) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [EXT_W-1:0] full;
    logic        [EXT_W-ACC_W:0] top_bits;

    assign full = $signed({{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc})
                + $signed({{(EXT_W-B){prod[B-1]}}, prod});

    // The result fits in ACC_W signed bits only if every bit from the
    // ACC_W sign position upward agrees.
    assign top_bits = full[EXT_W-1:ACC_W-1];

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ovf = !((&top_bits) || !(|top_bits));
        sum = full[ACC_W-1:0];
`ifdef PRODUCT_ACC_SAT_EN
        if (ovf) begin
            sum = full[EXT_W-1] ? SAT_MIN : SAT_MAX;
        end
`else
        // Wrap build keeps the low ACC_W bits: modulo 2^ACC_W.
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates N_TERMS signed products per run behind a start/valid/ready FSM.
// Saturation vs wrap is selected by PRODUCT_ACC_SAT_EN inside acc_sat_add.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int B       = B_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    prod_valid,
    input  logic signed [B-1:0]     prod,
    output logic                    prod_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    acc_valid,
    input  logic                    res_ready,
    output logic                    busy,
    output logic                    ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;

    // A start in ACCUM restarts the run, so the product offered that cycle
    // must not be acknowledged.
    assign prod_ready = (state == ACCUM) && !start;
    assign accept     = prod_valid && prod_ready;

    acc_sat_add #(
        .B     (B),
        .ACC_W (ACC_W)
    ) u_add (
        .acc  (acc_out),
        .prod (prod),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
        end else if (start) begin
            state     <= ACCUM;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            busy      <= 1'b1;
            ovf       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_out <= sum;
                        ovf     <= ovf | add_ovf;
                        cnt     <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        acc_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
